// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares one unified instruction/data memory port between the
//             EX-stage load/store path (m0) and the IF-stage fetch (m1).
//             Each access is sequenced IDLE -> BUSY -> RESP with a req/ack
//             handshake, alternating priority under contention, and a slave
//             timeout. hold_o stalls the pipeline while any access is pending.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             m0_*                - data master (read/write, byte enables)
//             m1_*                - fetch master (read only, full word)
//             s_*                 - shared slave port
//             hold_o              - pipeline hold request
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ack,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ack,
    output logic                m1_err,
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_be,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                hold_o
);

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic                r_owner, w_owner_next;
    logic                r_last_owner, w_last_owner_next;
    logic [7:0]          r_cnt, w_cnt_next;

    logic                w_s_req_next, w_s_we_next;
    logic [ADDR_W-1:0]   w_s_addr_next;
    logic [DATA_W-1:0]   w_s_wdata_next;
    logic [DATA_W/8-1:0] w_s_be_next;
    logic [DATA_W-1:0]   w_m0_rdata_next, w_m1_rdata_next;
    logic                w_m0_ack_next, w_m0_err_next;
    logic                w_m1_ack_next, w_m1_err_next;

    logic                w_grant_m1;
    logic [DATA_W-1:0]   w_rsp_data;

    // m1 wins when it is alone, or when both request and m0 was served last.
    assign w_grant_m1 = m1_req & (~m0_req | ~r_last_owner);

    // A write completion returns zero; a timeout also returns zero.
    assign w_rsp_data = (s_ack & ~s_we) ? s_rdata : '0;

    assign hold_o = (m0_req | m1_req) & ~(m0_ack | m1_ack);

    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_cnt_next        = r_cnt;
        w_s_req_next      = s_req;
        w_s_we_next       = s_we;
        w_s_addr_next     = s_addr;
        w_s_wdata_next    = s_wdata;
        w_s_be_next       = s_be;
        w_m0_rdata_next   = m0_rdata;
        w_m1_rdata_next   = m1_rdata;
        w_m0_ack_next     = 1'b0;
        w_m0_err_next     = 1'b0;
        w_m1_ack_next     = 1'b0;
        w_m1_err_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (m0_req | m1_req) begin
                    w_owner_next = w_grant_m1;
                    w_s_req_next = 1'b1;
                    w_cnt_next   = 8'd0;
                    w_state_next = ST_BUSY;
                    if (w_grant_m1) begin
                        w_s_we_next    = 1'b0;
                        w_s_addr_next  = m1_addr;
                        w_s_wdata_next = '0;
                        w_s_be_next    = '1;
                    end else begin
                        w_s_we_next    = m0_we;
                        w_s_addr_next  = m0_addr;
                        w_s_wdata_next = m0_wdata;
                        w_s_be_next    = m0_be;
                    end
                end
            end
            ST_BUSY: begin
                w_cnt_next = r_cnt + 8'd1;
                if (s_ack || (r_cnt == c_timeout_last)) begin
                    w_s_req_next = 1'b0;
                    w_state_next = ST_RESP;
                    if (r_owner) begin
                        w_m1_rdata_next = w_rsp_data;
                        w_m1_ack_next   = 1'b1;
                        w_m1_err_next   = ~s_ack;
                    end else begin
                        w_m0_rdata_next = w_rsp_data;
                        w_m0_ack_next   = 1'b1;
                        w_m0_err_next   = ~s_ack;
                    end
                end
            end
            ST_RESP: begin
                // ack is high during this state; requests are re-sampled
                // only after returning to IDLE, so a master releasing req on
                // this edge is never granted twice.
                w_last_owner_next = r_owner;
                w_state_next      = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= 8'd0;
            s_req        <= 1'b0;
            s_we         <= 1'b0;
            s_addr       <= '0;
            s_wdata      <= '0;
            s_be         <= '0;
            m0_rdata     <= '0;
            m0_ack       <= 1'b0;
            m0_err       <= 1'b0;
            m1_rdata     <= '0;
            m1_ack       <= 1'b0;
            m1_err       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_cnt        <= w_cnt_next;
            s_req        <= w_s_req_next;
            s_we         <= w_s_we_next;
            s_addr       <= w_s_addr_next;
            s_wdata      <= w_s_wdata_next;
            s_be         <= w_s_be_next;
            m0_rdata     <= w_m0_rdata_next;
            m0_ack       <= w_m0_ack_next;
            m0_err       <= w_m0_err_next;
            m1_rdata     <= w_m1_rdata_next;
            m1_ack       <= w_m1_ack_next;
            m1_err       <= w_m1_err_next;
        end
    end

endmodule
`default_nettype wire
